// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receiver with event FIFO.
//   - Event layout: {ext, brk, code[7:0]} (EVT_W bits, EXT_BIT/BRK_BIT offsets)
//   - Scan-code prefix bytes (E0 = extended, F0 = break)
//   - Frame FSM state encoding
//   - Helper functions for odd-parity checking and event packing
package ps2_pkg;

  localparam int EVT_W   = 10;
  localparam int EXT_BIT = 9;
  localparam int BRK_BIT = 8;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

  function automatic logic [EVT_W-1:0] make_evt(input logic ext, input logic brk,
                                                input logic [7:0] code);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: key-event stream between the PS/2 receiver and its consumer.
//   evt_data   head event {ext, brk, code}
//   evt_valid  FIFO not empty
//   evt_ready  consumer accepts the head event
//   fifo_level number of buffered events
// Modports: master = receiver (drives events), slave = consumer (drives ready).
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  import ps2_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [EVT_W-1:0] evt_data;
  logic             evt_valid;
  logic             evt_ready;
  logic [LVL_W-1:0] fifo_level;

  modport master (output evt_data, output evt_valid, output fifo_level, input evt_ready);
  modport slave  (input evt_data, input evt_valid, input fifo_level, output evt_ready);

endinterface

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous show-ahead FIFO for key events.
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data (ignored when full unless pop is accepted same cycle)
//   pop        remove head entry (ignored when empty)
//   head_data  head entry, forced to zero when empty
//   full/empty status flags; level = entries held
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [EVT_W-1:0]         push_data,
  input  logic                     pop,
  output logic [EVT_W-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [EVT_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             pop_en_s;
  logic             push_en_s;

  assign full  = (level_r == LVL_FULL);
  assign empty = (level_r == {(AW + 1){1'b0}});
  assign level = level_r;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_en_s  = pop && !empty;
    push_en_s = push && (!full || pop_en_s);
    if (empty) begin
      head_data = {EVT_W{1'b0}};
    end else begin
      head_data = mem_r[rd_ptr_r];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   level_r <= level_r + (AW + 1)'(1);
        2'b01:   level_r <= level_r - (AW + 1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with scan-code assembly and event FIFO.
// Pins are synchronised and glitch-filtered in the clk_100mhz domain; the filtered
// clock's falling edge drives an 11-bit frame FSM with odd-parity/stop check and a
// frame timeout. E0/F0 prefixes are folded into {ext, brk, code} events.
// Optional build macro: PS2_REPEAT_FILTER_EN drops typematic repeats of the last
// make event.
// Ports:
//   clk_100mhz, rst   system clock, asynchronous active-high reset
//   ps2_c, ps2_d      raw PS/2 pins
//   evt_if (master)   evt_data / evt_valid / evt_ready / fifo_level
//   frame_err         pulse per rejected or timed-out frame
//   overflow          pulse when an event is dropped on a full FIFO
//   overflow_flag     sticky overflow, cleared by clr_err
//   err_count         saturating frame_err counter, cleared by clr_err
//   clr_err           synchronous clear of err_count and overflow_flag
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk_100mhz,
  input  logic                 rst,
  input  logic                 ps2_c,
  input  logic                 ps2_d,
  ps2_rx_fifo_if.master        evt_if,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 overflow_flag,
  output logic [7:0]           err_count,
  input  logic                 clr_err
);

  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Input path
  logic                  c_meta_r, c_sync_r, d_meta_r, d_sync_r;
  logic [FILTER_LEN-1:0] c_hist_r, d_hist_r;
  logic                  c_filt_r, d_filt_r, c_filt_s, d_filt_s;
  logic                  strobe_r;

  // Frame FSM
  frame_state_e          state_r, state_s;
  logic [2:0]            bit_idx_r, bit_idx_s;
  logic [7:0]            shift_r, shift_s;
  logic                  par_r, par_s;
  logic [TO_W-1:0]       to_cnt_r, to_cnt_s;
  logic                  byte_valid_r, byte_valid_s;
  logic [7:0]            byte_r, byte_s;
  logic                  frame_err_r, frame_err_s;

  // Assembler / FIFO
  logic                  ext_r, ext_s, brk_r, brk_s;
  logic                  evt_ok_s, push_s, pop_s, drop_s, full_s, empty_s;
  logic [EVT_W-1:0]      push_data_s, head_s;
  logic [LVL_W-1:0]      level_s;
  logic                  overflow_r, overflow_flag_r;
  logic [7:0]            err_count_r;

  // Two-flop synchronisers, shift filters and registered falling-edge strobe.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      c_meta_r <= 1'b1;
      c_sync_r <= 1'b1;
      d_meta_r <= 1'b1;
      d_sync_r <= 1'b1;
      c_hist_r <= {FILTER_LEN{1'b1}};
      d_hist_r <= {FILTER_LEN{1'b1}};
      c_filt_r <= 1'b1;
      d_filt_r <= 1'b1;
      strobe_r <= 1'b0;
    end else begin
      c_meta_r <= ps2_c;
      c_sync_r <= c_meta_r;
      d_meta_r <= ps2_d;
      d_sync_r <= d_meta_r;
      c_hist_r <= {c_hist_r[FILTER_LEN-2:0], c_sync_r};
      d_hist_r <= {d_hist_r[FILTER_LEN-2:0], d_sync_r};
      c_filt_r <= c_filt_s;
      d_filt_r <= d_filt_s;
      strobe_r <= c_filt_r & ~c_filt_s;
    end
  end

  // Filtered line moves only when every sample in the window agrees.
  always_comb begin
    c_filt_s = c_filt_r;
    d_filt_s = d_filt_r;
    if (&c_hist_r) begin
      c_filt_s = 1'b1;
    end else if (~|c_hist_r) begin
      c_filt_s = 1'b0;
    end else begin
      c_filt_s = c_filt_r;
    end
    if (&d_hist_r) begin
      d_filt_s = 1'b1;
    end else if (~|d_hist_r) begin
      d_filt_s = 1'b0;
    end else begin
      d_filt_s = d_filt_r;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      to_cnt_r     <= {TO_W{1'b0}};
      byte_valid_r <= 1'b0;
      byte_r       <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_idx_r    <= bit_idx_s;
      shift_r      <= shift_s;
      par_r        <= par_s;
      to_cnt_r     <= to_cnt_s;
      byte_valid_r <= byte_valid_s;
      byte_r       <= byte_s;
      frame_err_r  <= frame_err_s;
    end
  end

  // Frame FSM next state: advances on the strobe; timeout overrides everything.
  always_comb begin
    state_s      = state_r;
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    par_s        = par_r;
    byte_s       = byte_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;

    if (state_r == IDLE || strobe_r) begin
      to_cnt_s = {TO_W{1'b0}};
    end else begin
      to_cnt_s = to_cnt_r + TO_W'(1);
    end

    if (state_r != IDLE && !strobe_r && to_cnt_r == TO_LAST) begin
      state_s     = IDLE;
      frame_err_s = 1'b1;
    end else if (strobe_r) begin
      case (state_r)
        IDLE: begin
          if (!d_filt_r) begin
            state_s   = DATA;
            bit_idx_s = 3'd0;
          end else begin
            state_s = IDLE;
          end
        end
        DATA: begin
          shift_s = {d_filt_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = PARITY;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end
        PARITY: begin
          par_s   = d_filt_r;
          state_s = STOP;
        end
        STOP: begin
          state_s = IDLE;
          if (odd_parity_ok(shift_r, par_r) && d_filt_r) begin
            byte_valid_s = 1'b1;
            byte_s       = shift_r;
          end else begin
            frame_err_s = 1'b1;
          end
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Prefix tracking: E0/F0 latch flags, any other byte becomes an event.
  always_comb begin
    ext_s       = ext_r;
    brk_s       = brk_r;
    evt_ok_s    = 1'b0;
    push_data_s = make_evt(ext_r, brk_r, byte_r);
    if (frame_err_r) begin
      ext_s = 1'b0;
      brk_s = 1'b0;
    end else if (byte_valid_r) begin
      if (byte_r == PS2_EXT) begin
        ext_s = 1'b1;
      end else if (byte_r == PS2_BRK) begin
        brk_s = 1'b1;
      end else begin
        evt_ok_s = 1'b1;
        ext_s    = 1'b0;
        brk_s    = 1'b0;
      end
    end else begin
      ext_s = ext_r;
      brk_s = brk_r;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       rec_valid_r, rec_valid_s, rec_ext_r, rec_ext_s;
  logic [7:0] rec_code_r, rec_code_s;
  logic       rec_match_s;

  // Typematic filter: repeated make of the held key is dropped, its break releases it.
  always_comb begin
    rec_valid_s = rec_valid_r;
    rec_ext_s   = rec_ext_r;
    rec_code_s  = rec_code_r;
    rec_match_s = rec_valid_r && (rec_ext_r == ext_r) && (rec_code_r == byte_r);
    push_s      = evt_ok_s && !(rec_match_s && !brk_r);
    if (evt_ok_s && brk_r && rec_match_s) begin
      rec_valid_s = 1'b0;
    end else if (push_s && !brk_r && !drop_s) begin
      rec_valid_s = 1'b1;
      rec_ext_s   = ext_r;
      rec_code_s  = byte_r;
    end else begin
      rec_valid_s = rec_valid_r;
    end
  end

  // Held make-event record.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      rec_valid_r <= 1'b0;
      rec_ext_r   <= 1'b0;
      rec_code_r  <= 8'h00;
    end else begin
      rec_valid_r <= rec_valid_s;
      rec_ext_r   <= rec_ext_s;
      rec_code_r  <= rec_code_s;
    end
  end
`else
  assign push_s = evt_ok_s;
`endif

  assign pop_s  = !empty_s && evt_if.evt_ready;
  assign drop_s = push_s && full_s && !pop_s;

  // Prefix flags, overflow reporting and saturating error counter.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      ext_r           <= 1'b0;
      brk_r           <= 1'b0;
      overflow_r      <= 1'b0;
      overflow_flag_r <= 1'b0;
      err_count_r     <= 8'h00;
    end else begin
      ext_r      <= ext_s;
      brk_r      <= brk_s;
      overflow_r <= drop_s;
      if (clr_err) begin
        overflow_flag_r <= 1'b0;
        err_count_r     <= 8'h00;
      end else begin
        if (drop_s) begin
          overflow_flag_r <= 1'b1;
        end
        if (frame_err_r && err_count_r != 8'hFF) begin
          err_count_r <= err_count_r + 8'd1;
        end
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_100mhz),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  assign evt_if.evt_data   = head_s;
  assign evt_if.evt_valid  = !empty_s;
  assign evt_if.fifo_level = level_s;
  assign frame_err         = frame_err_r;
  assign overflow          = overflow_r;
  assign overflow_flag     = overflow_flag_r;
  assign err_count         = err_count_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed self-checking bench for ps2_rx_fifo.
// Drives PS/2 frames on the raw pins and checks events, errors and FIFO status.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int TO_CYC = 1000;
  localparam int HALF   = 30;
`ifdef PS2_REPEAT_FILTER_EN
  localparam int REPEAT_EXP = 1;
`else
  localparam int REPEAT_EXP = 2;
`endif

  logic       clk = 1'b0;
  logic       rst, ps2_c, ps2_d, clr_err;
  logic       frame_err, overflow, overflow_flag;
  logic [7:0] err_count;

  ps2_rx_fifo_if #(.FIFO_DEPTH(8)) evt_if ();

  ps2_rx_fifo #(
    .FILTER_LEN(4), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_100mhz(clk), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d), .evt_if(evt_if),
    .frame_err(frame_err), .overflow(overflow), .overflow_flag(overflow_flag),
    .err_count(err_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [9:0] got_q[$];
  int ferr_cnt = 0;
  int ovf_cnt = 0;

  // Monitor on the inactive edge: accepted events and error/overflow pulses.
  always @(negedge clk) begin
    if (evt_if.evt_valid && evt_if.evt_ready) got_q.push_back(evt_if.evt_data);
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
  end

  function automatic logic [9:0] q_at(input int i);
    if (got_q.size() > i) return got_q[i];
    return 10'h3FF;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_d = f[i];
      wait_clk(HALF / 2);
      ps2_c = 1'b0;
      wait_clk(HALF);
      ps2_c = 1'b1;
      wait_clk(HALF / 2);
    end
    ps2_d = 1'b1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic flip);
    send_bits(frame_of(b, flip), 11);
    wait_clk(40);
  endtask

  task automatic clear_mon();
    got_q.delete();
    ferr_cnt = 0;
    ovf_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2_c = 1'b1; ps2_d = 1'b1; clr_err = 1'b0; evt_if.evt_ready = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(3);
    tests_run++; if (evt_if.evt_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", evt_if.evt_valid); end
    tests_run++; if (evt_if.evt_data !== 10'h000) begin tests_failed++; $display("FAIL reset_data got %h exp 000", evt_if.evt_data); end
    tests_run++; if (evt_if.fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", evt_if.fifo_level); end
    tests_run++; if ({frame_err, overflow, overflow_flag} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b exp 000", {frame_err, overflow, overflow_flag}); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_errcnt got %0d exp 0", err_count); end
  endtask

  task automatic test_single_make();
    evt_if.evt_ready = 1'b1;
    clear_mon();
    send_byte(8'h1C, 1'b0);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL make_count got %0d exp 1", got_q.size()); end
    tests_run++; if (q_at(0) !== 10'h01C) begin tests_failed++; $display("FAIL make_data got %h exp 01C", q_at(0)); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL make_errcnt got %0d exp 0", err_count); end
    send_byte(8'h1C, 1'b0);
    tests_run++; if (got_q.size() !== REPEAT_EXP) begin tests_failed++; $display("FAIL repeat_count got %0d exp %0d", got_q.size(), REPEAT_EXP); end
  endtask

  task automatic test_prefix();
    clear_mon();
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL brk_count got %0d exp 1", got_q.size()); end
    tests_run++; if (q_at(0) !== 10'h11C) begin tests_failed++; $display("FAIL brk_data got %h exp 11C", q_at(0)); end
    clear_mon();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL extbrk_count got %0d exp 1", got_q.size()); end
    tests_run++; if (q_at(0) !== 10'h375) begin tests_failed++; $display("FAIL extbrk_data got %h exp 375", q_at(0)); end
  endtask

  task automatic test_bad_parity();
    clear_mon();
    send_byte(8'h1C, 1'b1);
    tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL par_count got %0d exp 0", got_q.size()); end
    tests_run++; if (ferr_cnt !== 1) begin tests_failed++; $display("FAIL par_ferr got %0d exp 1", ferr_cnt); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL par_errcnt got %0d exp 1", err_count); end
    send_byte(8'h29, 1'b0);
    tests_run++; if (q_at(0) !== 10'h029) begin tests_failed++; $display("FAIL par_next got %h exp 029", q_at(0)); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    tests_run++; if (q_at(1) !== 10'h129) begin tests_failed++; $display("FAIL par_release got %h exp 129", q_at(1)); end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'hE0, 1'b0);
    send_bits(frame_of(8'h29, 1'b0), 5);
    wait_clk(TO_CYC + 100);
    tests_run++; if (ferr_cnt !== 1) begin tests_failed++; $display("FAIL to_ferr got %0d exp 1", ferr_cnt); end
    tests_run++; if (err_count !== 8'd2) begin tests_failed++; $display("FAIL to_errcnt got %0d exp 2", err_count); end
    send_byte(8'h29, 1'b0);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL to_count got %0d exp 1", got_q.size()); end
    tests_run++; if (q_at(0) !== 10'h029) begin tests_failed++; $display("FAIL to_data got %h exp 029", q_at(0)); end
  endtask

  task automatic test_overflow();
    logic [7:0] code;
    evt_if.evt_ready = 1'b0;
    clear_mon();
    for (int i = 0; i < 9; i++) begin
      code = 8'h15 + 8'(i);
      send_byte(code, 1'b0);
    end
    tests_run++; if (evt_if.fifo_level !== 4'd8) begin tests_failed++; $display("FAIL ovf_level got %0d exp 8", evt_if.fifo_level); end
    tests_run++; if (ovf_cnt !== 1) begin tests_failed++; $display("FAIL ovf_pulses got %0d exp 1", ovf_cnt); end
    tests_run++; if (overflow_flag !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b exp 1", overflow_flag); end
    tests_run++; if (evt_if.evt_data !== 10'h015) begin tests_failed++; $display("FAIL ovf_head got %h exp 015", evt_if.evt_data); end
    evt_if.evt_ready = 1'b1;
    wait_clk(20);
    tests_run++; if (got_q.size() !== 8) begin tests_failed++; $display("FAIL drain_count got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      code = 8'h15 + 8'(i);
      tests_run++; if (q_at(i) !== {2'b00, code}) begin tests_failed++; $display("FAIL drain_order[%0d] got %h exp %h", i, q_at(i), {2'b00, code}); end
    end
    tests_run++; if ({evt_if.evt_valid, evt_if.evt_data} !== 11'h000) begin tests_failed++; $display("FAIL drain_empty got %h exp 000", {evt_if.evt_valid, evt_if.evt_data}); end
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    wait_clk(1);
    tests_run++; if (overflow_flag !== 1'b0) begin tests_failed++; $display("FAIL clr_flag got %b exp 0", overflow_flag); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL clr_errcnt got %0d exp 0", err_count); end
  endtask

  task automatic test_reset_mid_frame();
    evt_if.evt_ready = 1'b0;
    clear_mon();
    send_byte(8'h15, 1'b0);
    send_byte(8'h16, 1'b0);
    send_byte(8'h17, 1'b0);
    tests_run++; if (evt_if.fifo_level !== 4'd3) begin tests_failed++; $display("FAIL mid_level got %0d exp 3", evt_if.fifo_level); end
    send_bits(frame_of(8'h1C, 1'b0), 7);
    rst = 1'b1;
    wait_clk(3);
    tests_run++; if ({evt_if.evt_valid, evt_if.evt_data} !== 11'h000) begin tests_failed++; $display("FAIL mid_rst_evt got %h exp 000", {evt_if.evt_valid, evt_if.evt_data}); end
    tests_run++; if (evt_if.fifo_level !== 4'd0) begin tests_failed++; $display("FAIL mid_rst_level got %0d exp 0", evt_if.fifo_level); end
    tests_run++; if ({frame_err, overflow, overflow_flag, err_count} !== 11'h000) begin tests_failed++; $display("FAIL mid_rst_flags got %h exp 000", {frame_err, overflow, overflow_flag, err_count}); end
    rst = 1'b0;
    wait_clk(5);
    evt_if.evt_ready = 1'b1;
    clear_mon();
    send_byte(8'h1C, 1'b0);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL post_rst_count got %0d exp 1", got_q.size()); end
    tests_run++; if (q_at(0) !== 10'h01C) begin tests_failed++; $display("FAIL post_rst_data got %h exp 01C", q_at(0)); end
    tests_run++; if (ferr_cnt !== 0) begin tests_failed++; $display("FAIL post_rst_ferr got %0d exp 0", ferr_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_prefix();
    test_bad_parity();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised successor of the single-register PS/2 keyboard receiver. The block oversamples ps2_c/ps2_d in the system clock domain and validates complete 11-bit frames. It assembles E0/F0-prefixed scan codes into key events and buffers them in a FIFO with a valid/ready handshake. It sits between the PS/2 pins and game/control logic, adding frame timeout, error counting and overflow reporting.

Parameters:
FILTER_LEN, 4, consecutive equal samples needed to change a filtered PS/2 line (2..16)
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
TIMEOUT_CYCLES, 200000, clk cycles without a filtered ps2_c falling edge before a partial frame is abandoned (2 ms at 100 MHz)

Ports:
clk_100mhz  in  1  system clock
rst  in  1  asynchronous, active-high reset
ps2_c  in  1  raw PS/2 clock pin
ps2_d  in  1  raw PS/2 data pin
evt_data  out  10  head event: [9]=ext (E0 seen), [8]=brk (F0 seen), [7:0]=scan code
evt_valid  out  1  FIFO not empty
evt_ready  in  1  consumer accepts head event
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
frame_err  out  1  one-cycle pulse per rejected or timed-out frame
overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full
overflow_flag  out  1  sticky copy of overflow; cleared by clr_err
err_count  out  8  saturating count of frame_err pulses; cleared by clr_err
clr_err  in  1  synchronous clear of err_count and overflow_flag

Behaviour:
- Reset values:
  - evt_valid=0, evt_data=0, fifo_level=0, frame_err=0, overflow=0, overflow_flag=0, err_count=0.
  - Filtered lines =1, FSM in IDLE, prefix flags clear, FIFO pointers 0.
  - Asserting reset mid-frame discards the partial frame and all queued events.
- Input path:
  - Each pin passes through a 2-flop synchroniser, then a FILTER_LEN shift filter.
  - The filtered value changes only when all FILTER_LEN samples agree; otherwise it holds.
  - A registered falling-edge strobe of the filtered clock is the only frame timing event.
  - No logic is clocked by ps2_c.
- Frame FSM (advances on the strobe only):
  - IDLE: data=0 -> DATA with bit index 0; data=1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first; after bit 7 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame is good iff XOR(data bits, parity)=1 (odd parity) and stop=1 -> byte_valid strobe. Always returns to IDLE.
- Frame errors:
  - A bad frame produces a frame_err pulse and clears the prefix flags.
  - Timeout: in any state other than IDLE, a counter reloads on every strobe. Reaching TIMEOUT_CYCLES forces IDLE, pulses frame_err and clears the prefix flags.
  - err_count increments on each frame_err and saturates at 255.
  - clr_err takes priority over a simultaneous increment; the count reads 0.
- Assembler (on byte_valid):
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte pushes {ext,brk,byte} and clears both flags.
  - Repeated prefixes are idempotent.
- FIFO:
  - Show-ahead: evt_data is the head entry whenever evt_valid=1; it is 0 when the FIFO is empty.
  - Pop when evt_valid && evt_ready.
  - Push when full and no pop: the event is dropped, overflow pulses and overflow_flag sets. FIFO contents are unchanged.
  - Push when full with a simultaneous pop: the push is accepted and fifo_level is unchanged.
  - Push when empty: evt_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - evt_valid rises exactly 2 clk after the stop-bit strobe when the FIFO was empty.
  - The strobe itself lags the raw pin edge by 2+FILTER_LEN+1 clk.

Optional Feature:
Macro PS2_REPEAT_FILTER_EN.
- Defined: the block holds one record {valid, ext, code} of the last make event pushed.
  - A make event equal to the held record is dropped as typematic repeat. It causes no push and no overflow.
  - A break event whose {ext,code} matches the record clears it.
  - A different make event replaces it.
  - Reset clears the record.
- Undefined: every assembled event is pushed; no record logic is present.

Decomposition:
- Package ps2_pkg:
  - Event field widths/offsets (EVT_W=10, EXT_BIT=9, BRK_BIT=8).
  - Prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Frame FSM state encoding (IDLE, DATA, PARITY, STOP).
- One sub-module, ps2_evt_fifo: synchronous show-ahead FIFO, parameter DEPTH, 10-bit data, with push/pop/full/empty/level.
- Filter, FSM, timeout and assembler stay in ps2_rx_fifo.

Test Plan:
1. Frame 0x1C (parity 0, stop 1), evt_ready=1 -> one event, evt_data=10'h01C, err_count=0.
   - Send 0x1C again: two events with PS2_REPEAT_FILTER_EN undefined, one when defined.
2. Bytes F0,1C -> single event 10'h11C. Bytes E0,F0,75 -> single event 10'h375.
3. 0x1C with parity bit=1 -> no event, one frame_err pulse, err_count=1. Next good 0x29 -> event 10'h029.
4. Start bit + 4 data bits, then clock idle for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE, prefix cleared.
   - Full frame 0x29 afterwards -> event 10'h029.
5. evt_ready=0, send 9 distinct make codes 0x15..0x1D:
   - fifo_level=8; overflow pulses once on 0x1D; overflow_flag=1.
   - Raise ready -> 0x15..0x1C pop in order.
   - clr_err -> overflow_flag=0.
6. Assert rst during bit 5 of a frame with 3 events queued -> all outputs at reset values, fifo_level=0.
   - Next full frame 0x1C decoded correctly.
